// File: rtl/cnn_pkg.sv
// ============================================================================
// Module   : cnn_pkg
// Purpose  : Shared geometry constants and state encoding for the CNN source side.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package cnn_pkg;

  localparam int IMG_W    = 66;
  localparam int IMG_H    = 66;
  localparam int IMG_AW   = 13;
  localparam int FLT_N    = 9;
  localparam int FLT_AW   = 4;
  localparam int DW       = 8;
  localparam int IMG_SIZE = IMG_W * IMG_H;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD_FLT = 3'd1;
  localparam logic [2:0] S_LOAD_IMG = 3'd2;
  localparam logic [2:0] S_READY    = 3'd3;
  localparam logic [2:0] S_SERVE    = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

endpackage

`default_nettype wire

// File: rtl/src_sram.sv
// ============================================================================
// Module   : src_sram
// Purpose  : 1W1R synchronous SRAM, depth 2^AW, registered read port.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module src_sram #(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
    if (rd_en) r_rd_data <= r_mem[rd_addr];
  end

  assign rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/cnn_src_mem.sv
// ============================================================================
// Module   : cnn_src_mem
// Purpose  : Loads one frame (filter taps + padded image) from a host stream and
//            answers CNN image/filter reads with fixed one-cycle latency.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module cnn_src_mem
  import cnn_pkg::*;
#(
  parameter int IMG_W  = cnn_pkg::IMG_W,
  parameter int IMG_H  = cnn_pkg::IMG_H,
  parameter int IMG_AW = cnn_pkg::IMG_AW,
  parameter int FLT_N  = cnn_pkg::FLT_N,
  parameter int FLT_AW = cnn_pkg::FLT_AW,
  parameter int DW     = cnn_pkg::DW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DW-1:0]     load_data,
  output logic              load_ready,
  output logic              image_ready,
  input  logic              image_rden,
  input  logic [IMG_AW-1:0] image_addr,
  output logic [DW-1:0]     image_data,
  output logic              image_valid,
  input  logic              filter_rden,
  input  logic [FLT_AW-1:0] filter_addr,
  output logic [DW-1:0]     filter_data,
  output logic              filter_valid,
  output logic              frame_served
);

  localparam int c_img_size = IMG_W * IMG_H;

  logic [2:0]        r_state;
  logic [FLT_AW-1:0] r_flt_cnt;
  logic [IMG_AW-1:0] r_img_cnt;
  logic [IMG_AW:0]   r_served_cnt;
  logic [DW-1:0]     r_flt_mem [FLT_N];
  logic              r_image_ready;
  logic              r_image_valid;
  logic              r_img_oor;
  logic              r_filter_valid;
  logic [DW-1:0]     r_filter_data;
  logic              r_frame_served;

  logic              w_flt_wr;
  logic              w_img_wr;
  logic              w_img_rd;
  logic              w_img_in_range;
  logic              w_flt_rd;
  logic              w_flt_in_range;
  logic [DW-1:0]     w_sram_rdata;

  assign w_flt_wr       = (r_state == S_LOAD_FLT) && load_valid;
  assign w_img_wr       = (r_state == S_LOAD_IMG) && load_valid;
  assign w_img_rd       = image_rden &&
                          ((r_state == S_READY) || (r_state == S_SERVE) || (r_state == S_DONE));
  assign w_img_in_range = {1'b0, image_addr} < (IMG_AW+1)'(c_img_size);
  assign w_flt_rd       = filter_rden && (r_state != S_LOAD_FLT);
  assign w_flt_in_range = {1'b0, filter_addr} < (FLT_AW+1)'(FLT_N);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_flt_cnt      <= '0;
      r_img_cnt      <= '0;
      r_served_cnt   <= '0;
      r_image_ready  <= 1'b0;
      r_frame_served <= 1'b0;
    end else begin
      r_frame_served <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (load_start) begin
            r_state      <= S_LOAD_FLT;
            r_flt_cnt    <= '0;
            r_img_cnt    <= '0;
            r_served_cnt <= '0;
          end
        end
        S_LOAD_FLT: begin
          if (load_valid) begin
            r_flt_cnt <= r_flt_cnt + 1'b1;
            if (r_flt_cnt == FLT_AW'(FLT_N-1)) r_state <= S_LOAD_IMG;
          end
        end
        S_LOAD_IMG: begin
          if (load_valid) begin
            r_img_cnt <= r_img_cnt + 1'b1;
            if (r_img_cnt == IMG_AW'(c_img_size-1)) begin
              r_state       <= S_READY;
              r_image_ready <= 1'b1;
            end
          end
        end
        S_READY: begin
          if (image_rden) begin
            r_state       <= S_SERVE;
            r_image_ready <= 1'b0;
            if (w_img_in_range) r_served_cnt <= r_served_cnt + 1'b1;
          end
        end
        S_SERVE: begin
          // Out-of-range reads are answered but never advance the frame count.
          if (r_served_cnt == (IMG_AW+1)'(c_img_size)) begin
            r_state        <= S_DONE;
            r_frame_served <= 1'b1;
          end else if (image_rden && w_img_in_range) begin
            r_served_cnt <= r_served_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Filter taps are plain flops with no reset so a mid-frame reset keeps them.
  always_ff @(posedge clk) begin
    if (w_flt_wr) r_flt_mem[r_flt_cnt] <= load_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_image_valid  <= 1'b0;
      r_img_oor      <= 1'b0;
      r_filter_valid <= 1'b0;
      r_filter_data  <= '0;
    end else begin
      r_image_valid  <= w_img_rd;
      r_filter_valid <= w_flt_rd;
      if (w_img_rd) r_img_oor <= !w_img_in_range;
      if (w_flt_rd) r_filter_data <= w_flt_in_range ? r_flt_mem[filter_addr] : '0;
    end
  end

  src_sram #(
    .AW (IMG_AW),
    .DW (DW)
  ) u_src_sram (
    .clk     (clk),
    .wr_en   (w_img_wr),
    .wr_addr (r_img_cnt),
    .wr_data (load_data),
    .rd_en   (w_img_rd),
    .rd_addr (image_addr),
    .rd_data (w_sram_rdata)
  );

  assign load_ready   = (r_state == S_LOAD_FLT) || (r_state == S_LOAD_IMG);
  assign image_ready  = r_image_ready;
  assign image_valid  = r_image_valid;
  assign image_data   = (r_image_valid && !r_img_oor) ? w_sram_rdata : '0;
  assign filter_valid = r_filter_valid;
  assign filter_data  = r_filter_data;
  assign frame_served = r_frame_served;

endmodule

`default_nettype wire

// File: tb/tb_cnn_src_mem.sv
// ============================================================================
// Module   : tb_cnn_src_mem
// Purpose  : Scoreboard bench for cnn_src_mem: frame load, image/filter serve, reset.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cnn_src_mem;
  import cnn_pkg::*;

  localparam int c_img_size = IMG_W * IMG_H;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_start = 1'b0;
  logic              load_valid = 1'b0;
  logic [DW-1:0]     load_data = '0;
  logic              load_ready;
  logic              image_ready;
  logic              image_rden = 1'b0;
  logic [IMG_AW-1:0] image_addr = '0;
  logic [DW-1:0]     image_data;
  logic              image_valid;
  logic              filter_rden = 1'b0;
  logic [FLT_AW-1:0] filter_addr = '0;
  logic [DW-1:0]     filter_data;
  logic              filter_valid;
  logic              frame_served;

  int n_checks = 0;
  int n_errors = 0;
  int fs_cnt   = 0;
  int exp_img;
  int exp_flt;
  logic [DW-1:0] img_q[$];
  logic [DW-1:0] flt_q[$];

  always #5 clk = ~clk;

  cnn_src_mem dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_start   (load_start),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_ready   (load_ready),
    .image_ready  (image_ready),
    .image_rden   (image_rden),
    .image_addr   (image_addr),
    .image_data   (image_data),
    .image_valid  (image_valid),
    .filter_rden  (filter_rden),
    .filter_addr  (filter_addr),
    .filter_data  (filter_data),
    .filter_valid (filter_valid),
    .frame_served (frame_served)
  );

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] img_pat(input int sel, input int a);
    return (sel == 0) ? 8'(a) : 8'(a * 3 + 7);
  endfunction

  // Scoreboard: every valid response pops one expected entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (image_valid) begin
        if (img_q.size() == 0) check("img_unexpected_valid", 1, 0);
        else begin
          exp_img = int'(img_q.pop_front());
          check("img_data", int'(image_data), exp_img);
        end
      end
      if (filter_valid) begin
        if (flt_q.size() == 0) check("flt_unexpected_valid", 1, 0);
        else begin
          exp_flt = int'(flt_q.pop_front());
          check("flt_data", int'(filter_data), exp_flt);
        end
      end
      if (frame_served) fs_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame(input int fbase, input int sel);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    load_valid = 1'b0;
    check("load_ready_flt", int'(load_ready), 1);
    for (int i = 0; i < FLT_N + c_img_size; i++) begin
      while ($urandom_range(1) == 1) tick();
      if (i == 3) begin
        filter_rden = 1'b1;
        filter_addr = '0;
        tick();
        filter_rden = 1'b0;
        check("flt_rd_in_load_flt", int'(filter_valid), 0);
      end
      if (i == FLT_N + 100) begin
        image_rden = 1'b1;
        image_addr = IMG_AW'(100);
        load_start = 1'b1;
        tick();
        image_rden = 1'b0;
        load_start = 1'b0;
        check("img_rd_in_load", int'(image_valid), 0);
        check("load_ready_img", int'(load_ready), 1);
      end
      if (i == FLT_N + c_img_size - 1) check("image_ready_early", int'(image_ready), 0);
      load_valid = 1'b1;
      load_data  = (i < FLT_N) ? 8'(fbase + i) : img_pat(sel, i - FLT_N);
      tick();
      load_valid = 1'b0;
    end
    check("image_ready_rise", int'(image_ready), 1);
    check("load_ready_ready", int'(load_ready), 0);
  endtask

  task automatic flt_readback(input int fbase);
    for (int i = 0; i <= FLT_N; i++) begin
      filter_rden = 1'b1;
      filter_addr = FLT_AW'(i);
      flt_q.push_back((i < FLT_N) ? 8'(fbase + i) : 8'd0);
      tick();
      check("flt_valid_cont", int'(filter_valid), 1);
    end
    filter_rden = 1'b0;
    tick();
    check("flt_valid_idle", int'(filter_valid), 0);
    check("flt_q_drained", flt_q.size(), 0);
  endtask

  task automatic img_rd(input int addr, input int sel);
    image_rden = 1'b1;
    image_addr = IMG_AW'(addr);
    img_q.push_back((addr < c_img_size) ? img_pat(sel, addr) : 8'd0);
    tick();
  endtask

  task automatic img_drain();
    image_rden = 1'b0;
    tick();
    check("img_q_drained", img_q.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    check("rst_image_ready", int'(image_ready), 0);
    check("rst_image_valid", int'(image_valid), 0);
    check("rst_image_data", int'(image_data), 0);
    check("rst_filter_valid", int'(filter_valid), 0);
    check("rst_filter_data", int'(filter_data), 0);
    check("rst_load_ready", int'(load_ready), 0);
    check("rst_frame_served", int'(frame_served), 0);
    rst_n = 1'b1;
    tick();

    // Frame 1: taps 1..9, image = addr[7:0]
    load_frame(1, 0);
    flt_readback(1);
    img_rd(0, 0);
    check("image_ready_fall", int'(image_ready), 0);
    check("img_valid_first", int'(image_valid), 1);
    for (int a = 1; a < c_img_size; a++) begin
      if (a == 2000) begin
        img_rd(c_img_size, 0);
        img_rd(8191, 0);
      end
      img_rd(a, 0);
    end
    image_rden = 1'b0;
    check("frame_served_early", fs_cnt, 0);
    repeat (3) tick();
    check("frame_served_once", fs_cnt, 1);
    check("img_q_frame1", img_q.size(), 0);

    // Late reads in DONE are still answered
    img_rd(5, 0);
    img_rd(4400, 0);
    img_drain();

    // Frame 2 started from DONE
    load_frame(10, 1);
    flt_readback(10);
    for (int a = 0; a < 100; a++) img_rd((a * 37) % c_img_size, 1);
    img_drain();

    // Reset in the middle of SERVE with a read in flight
    filter_rden = 1'b1;
    filter_addr = FLT_AW'(2);
    flt_q.push_back(8'd12);
    img_rd(50, 1);
    filter_rden = 1'b0;
    image_addr  = IMG_AW'(60);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    tick();
    check("midrst_image_valid", int'(image_valid), 0);
    check("midrst_image_data", int'(image_data), 0);
    check("midrst_filter_valid", int'(filter_valid), 0);
    check("midrst_filter_data", int'(filter_data), 0);
    check("midrst_image_ready", int'(image_ready), 0);
    check("midrst_load_ready", int'(load_ready), 0);
    check("midrst_frame_served", int'(frame_served), 0);
    image_rden = 1'b0;
    img_q.delete();
    flt_q.delete();
    rst_n = 1'b1;
    tick();

    // Image read in IDLE is dropped
    image_rden = 1'b1;
    image_addr = IMG_AW'(3);
    tick();
    image_rden = 1'b0;
    check("img_rd_idle", int'(image_valid), 0);

    // Frame 3: byte presented together with load_start must be ignored
    load_valid = 1'b1;
    load_data  = 8'hEE;
    load_frame(20, 0);
    flt_readback(20);
    for (int a = 0; a < 300; a++) img_rd(a, 0);
    img_rd(c_img_size - 1, 0);
    img_drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
